vga_sink: RTL
=============

VGA_SINK -- requirements
Module: vga_sink

Interface
REQ-001 SHALL have port clk, input, 1 bit: 50 MHz system clock, the same clock that drives the VGA generator.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have ports VGA_CLK, VGA_HS, VGA_VS and VGA_BLANK_n, each an input of 1 bit: the monitored VGA timing signals (HS/VS active-low).
REQ-004 SHALL have ports VGA_R, VGA_G and VGA_B, each an input of 8 bits: the monitored pixel colour.
REQ-005 SHALL have port err_clear, input, 1 bit: synchronous clear of all sticky error flags.
REQ-006 SHALL have port pix_valid, output, 1 bit: one-cycle strobe marking one decoded active pixel.
REQ-007 SHALL have ports pix_x and pix_y, each an output of 10 bits: column and row of the strobed pixel.
REQ-008 SHALL have port pix_rgb, output, 24 bits: {R,G,B} of the strobed pixel.
REQ-009 SHALL have port pix_index, output, 4 bits: palette index decoded from pix_rgb.
REQ-010 SHALL have port pix_unknown, output, 1 bit: pix_rgb matches no palette entry.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle strobe at the end of each checked frame.
REQ-012 SHALL have port frame_count, output, 16 bits: number of completed frames.
REQ-013 SHALL have ports err_hlen, err_vlen and err_hsync, each an output of 1 bit: sticky timing-error flags.
REQ-014 SHALL have port synced, output, 1 bit: the FSM is in SYNCED.

Function
REQ-015 SHALL register all VGA inputs into an input stage on every clk edge; all decoding uses only the registered values.
REQ-016 SHALL define a pixel tick as the registered VGA_CLK being 1 while its previous registered value was 0; every counter below advances only on ticks.
REQ-017 SHALL implement FSM IDLE -> SYNCED: IDLE ignores all pixels; the first tick with registered VGA_VS rising (0->1) moves to SYNCED with y=0, x=0.
REQ-018 In SYNCED, on a tick with VGA_BLANK_n=1, SHALL emit the pixel (pix_x=x, pix_y=y, pix_rgb, pix_index) and then increment x.
REQ-019 SHALL make pix_valid high for exactly one cycle, on the 2nd clk edge after the edge where VGA_CLK first samples high; all pix_* outputs hold between strobes.
REQ-020 On a tick where VGA_BLANK_n falls (1->0), SHALL set err_hlen if x!=640, then set x=0 and increment y.
REQ-021 x and y SHALL saturate at 1023, and saturation SHALL set the corresponding flag: err_hlen for x, err_vlen for y.
REQ-022 SHALL count ticks while VGA_HS=0; on the HS rising edge, SHALL set err_hsync if the count !=96, then clear the count.
REQ-023 On a tick where VGA_VS falls in SYNCED, SHALL set err_vlen if y!=480, pulse frame_done for one cycle, increment frame_count (wraps 0xFFFF->0) and set y=0.
REQ-024 SHALL decode the palette as: ffffff->0, 00ff00->1, 0000ff->2, ff0000->3, ffff00->4, 00ffff->5, ff00ff->6, 808080->7, 000000->8.
REQ-025 Any colour not listed in REQ-024 SHALL give pix_index=F and pix_unknown=1; pix_unknown is 0 otherwise.
REQ-026 If err_clear and an error event occur in the same cycle, the error SHALL win (the flag stays 1).
REQ-027 In IDLE, SHALL never assert pix_valid or frame_done and SHALL not update the error flags.
REQ-028 Simultaneous BLANK_n fall and VS fall on one tick SHALL be processed as the line end first, then the frame end.

Reset
REQ-029 While reset=0, SHALL hold FSM=IDLE and all counters at 0.
REQ-030 While reset=0, SHALL hold outputs at: pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, pix_index=0, pix_unknown=0, frame_done=0, frame_count=0, err_*=0, synced=0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately, asynchronously.
REQ-032 After reset deasserts, the block SHALL resynchronise only on the next VS rising edge; no partial frame is reported.

Verification
REQ-033 Drive two nominal 640x480 frames (1600-clk lines, 525 lines) from the VGA generator -> 307200 pix_valid per frame, last pixel (639,479), frame_count=2, all err_*=0.
REQ-034 Drive sprite colour 3 at pixel (100,50) -> strobe with pix_x=100, pix_y=50, pix_rgb=ff0000, pix_index=3.
REQ-035 Shorten one active line to 639 pixels -> err_hlen=1 after that line; other flags 0; err_clear then gives err_hlen=0.
REQ-036 Stretch the HS pulse to 97 ticks -> err_hsync=1; frame_count still increments.
REQ-037 Assert reset at line 200, release it, then run 1.5 frames -> no pix_valid before the next VS rising edge, then a full clean frame, frame_count=1.
REQ-038 Drive colour 123456 -> pix_index=F, pix_unknown=1.

Source files
------------

// File: rtl/vga_sink.sv
// vga_sink: passive monitor for a 640x480 VGA timing generator.
// Samples the VGA pins on the system clock, recovers pixel ticks from
// VGA_CLK, reports every active pixel with its coordinates and palette
// index, counts frames and raises sticky flags on malformed timing.
// Geometry parameters default to 640x480 with a 96-tick HS pulse.
module vga_sink #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned HS_PULSE = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_n,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        err_clear,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic [3:0]  pix_index,
    output logic        pix_unknown,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        err_hsync,
    output logic        synced
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SYNCED = 1'b1
    } state_t;

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_END   = 10'(H_ACTIVE);
    localparam logic [9:0] V_END   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_END  = 10'(HS_PULSE);

    // Palette lookup; 4'hF means the colour is not in the palette.
    function automatic logic [3:0] palette_decode(input logic [23:0] rgb);
        logic [3:0] idx;
        case (rgb)
            24'hffffff: idx = 4'd0;
            24'h00ff00: idx = 4'd1;
            24'h0000ff: idx = 4'd2;
            24'hff0000: idx = 4'd3;
            24'hffff00: idx = 4'd4;
            24'h00ffff: idx = 4'd5;
            24'hff00ff: idx = 4'd6;
            24'h808080: idx = 4'd7;
            24'h000000: idx = 4'd8;
            default:    idx = 4'hF;
        endcase
        return idx;
    endfunction

    // input stage
    logic        vclk_r;
    logic        vclk_d_r;
    logic        hs_r;
    logic        vs_r;
    logic        blank_r;
    logic [23:0] rgb_r;

    // tick-domain history and counters
    state_t      state_r;
    logic        hs_last_r;
    logic        vs_last_r;
    logic        blank_last_r;
    logic [9:0]  x_r;
    logic [9:0]  y_r;
    logic [9:0]  hs_cnt_r;

    // pixel staged between the tick and the output strobe
    logic        pend_valid_r;
    logic [9:0]  pend_x_r;
    logic [9:0]  pend_y_r;
    logic [23:0] pend_rgb_r;

    logic        tick_s;
    logic        pixel_s;
    logic        line_end_s;
    logic        vs_rise_s;
    logic        vs_fall_s;
    logic        hs_rise_s;
    logic [9:0]  y_line_s;
    logic        set_hlen_s;
    logic        set_vlen_s;
    logic        set_hsync_s;
    logic [3:0]  pend_index_s;

    // Register every VGA pin; all decoding below uses only these copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vclk_r   <= 1'b0;
            vclk_d_r <= 1'b0;
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
            blank_r  <= 1'b0;
            rgb_r    <= 24'h000000;
        end else begin
            vclk_r   <= VGA_CLK;
            vclk_d_r <= vclk_r;
            hs_r     <= VGA_HS;
            vs_r     <= VGA_VS;
            blank_r  <= VGA_BLANK_n;
            rgb_r    <= {VGA_R, VGA_G, VGA_B};
        end
    end

    // Edge events, all qualified by the pixel tick (VGA_CLK rising).
    assign tick_s       = vclk_r & ~vclk_d_r;
    assign pixel_s      = tick_s & blank_r;
    assign line_end_s   = tick_s & blank_last_r & ~blank_r;
    assign vs_rise_s    = tick_s & ~vs_last_r & vs_r;
    assign vs_fall_s    = tick_s & vs_last_r & ~vs_r;
    assign hs_rise_s    = tick_s & ~hs_last_r & hs_r;
    assign pend_index_s = palette_decode(pend_rgb_r);

    // Error events and the row after any line end; the line end is resolved
    // before the frame end so a shared tick checks the updated row count.
    always_comb begin
        y_line_s    = y_r;
        set_hlen_s  = 1'b0;
        set_vlen_s  = 1'b0;
        set_hsync_s = 1'b0;
        if (state_r == SYNCED) begin
            if (pixel_s) begin
                set_hlen_s = (x_r == CNT_MAX);
            end else if (line_end_s) begin
                set_hlen_s = (x_r != H_END);
                if (y_r == CNT_MAX) begin
                    y_line_s   = CNT_MAX;
                    set_vlen_s = 1'b1;
                end else begin
                    y_line_s = y_r + 10'd1;
                end
            end else begin
                set_hlen_s = 1'b0;
            end
            set_vlen_s  = set_vlen_s | (vs_fall_s & (y_line_s != V_END));
            set_hsync_s = hs_rise_s & (hs_cnt_r != HS_END);
        end else begin
            y_line_s = y_r;
        end
    end

    // Sync FSM with pixel/line/frame counters; advances only on ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            synced       <= 1'b0;
            hs_last_r    <= 1'b1;
            vs_last_r    <= 1'b1;
            blank_last_r <= 1'b0;
            x_r          <= 10'd0;
            y_r          <= 10'd0;
            hs_cnt_r     <= 10'd0;
            pend_valid_r <= 1'b0;
            pend_x_r     <= 10'd0;
            pend_y_r     <= 10'd0;
            pend_rgb_r   <= 24'h000000;
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
        end else begin
            pend_valid_r <= 1'b0;
            frame_done   <= 1'b0;
            if (tick_s) begin
                hs_last_r    <= hs_r;
                vs_last_r    <= vs_r;
                blank_last_r <= blank_r;
                if (hs_rise_s) begin
                    hs_cnt_r <= 10'd0;
                end else if (!hs_r && (hs_cnt_r != CNT_MAX)) begin
                    hs_cnt_r <= hs_cnt_r + 10'd1;
                end else begin
                    hs_cnt_r <= hs_cnt_r;
                end
                case (state_r)
                    IDLE: begin
                        if (vs_rise_s) begin
                            state_r <= SYNCED;
                            synced  <= 1'b1;
                            x_r     <= 10'd0;
                            y_r     <= 10'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    SYNCED: begin
                        if (pixel_s) begin
                            pend_valid_r <= 1'b1;
                            pend_x_r     <= x_r;
                            pend_y_r     <= y_r;
                            pend_rgb_r   <= rgb_r;
                            x_r          <= (x_r == CNT_MAX) ? CNT_MAX : x_r + 10'd1;
                        end else if (line_end_s) begin
                            x_r <= 10'd0;
                        end else begin
                            x_r <= x_r;
                        end
                        if (vs_fall_s) begin
                            y_r         <= 10'd0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            y_r <= y_line_s;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        synced  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky error flags; a new event in the same cycle beats err_clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_hlen  <= 1'b0;
            err_vlen  <= 1'b0;
            err_hsync <= 1'b0;
        end else begin
            err_hlen  <= set_hlen_s  | (err_hlen  & ~err_clear);
            err_vlen  <= set_vlen_s  | (err_vlen  & ~err_clear);
            err_hsync <= set_hsync_s | (err_hsync & ~err_clear);
        end
    end

    // Present the staged pixel with its palette index; hold between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 24'h000000;
            pix_index   <= 4'd0;
            pix_unknown <= 1'b0;
        end else begin
            pix_valid <= pend_valid_r;
            if (pend_valid_r) begin
                pix_x       <= pend_x_r;
                pix_y       <= pend_y_r;
                pix_rgb     <= pend_rgb_r;
                pix_index   <= pend_index_s;
                pix_unknown <= (pend_index_s == 4'hF);
            end else begin
                pix_x       <= pix_x;
                pix_y       <= pix_y;
                pix_rgb     <= pix_rgb;
                pix_index   <= pix_index;
                pix_unknown <= pix_unknown;
            end
        end
    end

endmodule
